// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC, one-outstanding imem request, redirect and HLT
// FETCH_SKID_EN adds a one-entry skid buffer so the next fetch can overlap a stalled decode.
module fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [15:0] branch_target,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ready,
  input  logic [15:0] imem_rdata,
  output logic [15:0] instr,
  output logic        instr_valid,
  output logic [15:0] pc_out,
  output logic [15:0] pc_plus2,
  output logic        halted
);
  localparam logic [1:0] S_REQ   = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_HALT  = 2'd3;

  logic [1:0]  state;
  logic [15:0] pc;
  logic [15:0] pc_inc;
  logic        started;
  logic        out_valid;
  logic [15:0] out_instr;
  logic [15:0] out_pc;
  logic [15:0] out_pc2;
  logic        issue_ok;
  logic        consume;
  logic        capture;
  logic        land_out;
  logic        in_flight;
  logic        target_lsb_unused;

`ifdef FETCH_SKID_EN
  logic        skid_valid;
  logic [15:0] skid_instr;
  logic [15:0] skid_pc;
  logic [15:0] skid_pc2;
  assign issue_ok = !skid_valid;
`else
  assign issue_ok = !out_valid;
`endif

  assign pc_inc            = pc + 16'd2;
  assign target_lsb_unused = branch_target[0];

  // started holds imem_req low through the reset cycles even though state already reads REQ
  assign imem_req  = started && (state == S_REQ) && issue_ok;
  assign imem_addr = pc;
  assign consume   = out_valid && !stall;
  assign capture   = (state == S_WAIT) && imem_ready;
  assign land_out  = !out_valid || consume;
  assign in_flight = imem_req || (((state == S_WAIT) || (state == S_DRAIN)) && !imem_ready);

  assign instr       = out_instr;
  assign instr_valid = out_valid;
  assign pc_out      = out_pc;
  assign pc_plus2    = out_pc2;
  assign halted      = (state == S_HALT);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_REQ;
      pc        <= RESET_PC;
      started   <= 1'b0;
      out_valid <= 1'b0;
      out_instr <= 16'h0000;
      out_pc    <= 16'h0000;
      out_pc2   <= 16'h0000;
`ifdef FETCH_SKID_EN
      skid_valid <= 1'b0;
      skid_instr <= 16'h0000;
      skid_pc    <= 16'h0000;
      skid_pc2   <= 16'h0000;
`endif
    end else begin
      started <= 1'b1;
      if (branch_taken) begin
        pc        <= {branch_target[15:1], 1'b0};
        out_valid <= 1'b0;
`ifdef FETCH_SKID_EN
        skid_valid <= 1'b0;
`endif
        state <= in_flight ? S_DRAIN : S_REQ;
      end else begin
        if (capture && land_out) begin
          out_valid <= 1'b1;
          out_instr <= imem_rdata;
          out_pc    <= pc;
          out_pc2   <= pc_inc;
        end
`ifdef FETCH_SKID_EN
        else if (consume && skid_valid) begin
          out_instr  <= skid_instr;
          out_pc     <= skid_pc;
          out_pc2    <= skid_pc2;
          skid_valid <= 1'b0;
        end
`endif
        else if (consume) begin
          out_valid <= 1'b0;
        end
`ifdef FETCH_SKID_EN
        // a request only issues with the skid empty, so this never overwrites a held entry
        if (capture && !land_out) begin
          skid_valid <= 1'b1;
          skid_instr <= imem_rdata;
          skid_pc    <= pc;
          skid_pc2   <= pc_inc;
        end
`endif
        case (state)
          S_REQ:   if (imem_req) state <= S_WAIT;
          S_WAIT:  if (imem_ready) begin
                     pc    <= pc_inc;
                     state <= (imem_rdata[15:12] == 4'hF) ? S_HALT : S_REQ;
                   end
          S_DRAIN: if (imem_ready) state <= S_REQ;
          default: state <= S_HALT;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit with a variable-latency memory model
`timescale 1ns/1ps
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        branch_taken;
  logic [15:0] branch_target;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ready;
  logic [15:0] imem_rdata;
  logic [15:0] instr;
  logic        instr_valid;
  logic [15:0] pc_out;
  logic [15:0] pc_plus2;
  logic        halted;

`ifdef FETCH_SKID_EN
  localparam int SPACING = 2;
`else
  localparam int SPACING = 3;
`endif

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          mem_lat  = 1;
  int          mem_cnt  = 0;
  logic [15:0] mem_addr = 16'h0000;
  logic [15:0] mem [logic [15:0]];
  logic [47:0] sb_q [$];

  fetch_unit #(.RESET_PC(16'h0100)) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ready    (imem_ready),
    .imem_rdata    (imem_rdata),
    .instr         (instr),
    .instr_valid   (instr_valid),
    .pc_out        (pc_out),
    .pc_plus2      (pc_plus2),
    .halted        (halted)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] mem_rd(input logic [15:0] a);
    return mem.exists(a) ? mem[a] : 16'h0000;
  endfunction

  // Memory responds mem_lat cycles after the request cycle; expected deliveries are queued at issue.
  initial begin : mem_and_sb
    logic [47:0] e;
    imem_ready = 1'b0;
    imem_rdata = 16'h0000;
    forever begin
      @(negedge clk);
      if (instr_valid && !stall) begin
        if (sb_q.size() == 0) begin
          check_eq("sb_underflow", 32'(sb_q.size()), 32'd1);
        end else begin
          e = sb_q.pop_front();
          check_eq("sb_instr", 32'(instr), 32'(e[47:32]));
          check_eq("sb_pc", 32'(pc_out), 32'(e[31:16]));
          check_eq("sb_pc_plus2", 32'(pc_plus2), 32'(e[15:0]));
        end
      end
      if (branch_taken) sb_q.delete();
      imem_ready = 1'b0;
      if (mem_cnt > 0) begin
        mem_cnt--;
        if (mem_cnt == 0) begin
          imem_ready = 1'b1;
          imem_rdata = mem_rd(mem_addr);
        end
      end
      if (imem_req) begin
        mem_cnt  = mem_lat;
        mem_addr = imem_addr;
        if (!branch_taken) sb_q.push_back({mem_rd(imem_addr), imem_addr, imem_addr + 16'd2});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic sig(input int which);
    case (which)
      0:       return instr_valid;
      1:       return imem_req;
      default: return halted;
    endcase
  endfunction

  task automatic wait_for(input int which, input string tag, output int waited);
    waited = 0;
    while (!sig(which) && waited < 200) begin
      tick();
      waited++;
    end
    if (waited >= 200) check_eq(tag, 32'd0, 32'd1);
  endtask

  task automatic redirect(input logic [15:0] tgt);
    branch_taken  = 1'b1;
    branch_target = tgt;
    tick();
    branch_taken  = 1'b0;
  endtask

  initial begin : main
    int w, t1, t2, nreq;
    rst = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = 16'h0000;
    mem[16'h0100] = 16'h1234; mem[16'h0102] = 16'h5678; mem[16'h0104] = 16'hF000;

    repeat (3) tick();
    check_eq("rst_req", 32'(imem_req), 32'd0);
    check_eq("rst_valid", 32'(instr_valid), 32'd0);
    check_eq("rst_instr", 32'(instr), 32'd0);
    check_eq("rst_pc", 32'(pc_out), 32'd0);
    check_eq("rst_pc2", 32'(pc_plus2), 32'd0);
    check_eq("rst_halted", 32'(halted), 32'd0);
    check_eq("rst_addr", 32'(imem_addr), 32'h0100);
    rst = 1'b1;
    tick();
    check_eq("first_req", 32'(imem_req), 32'd1);
    check_eq("first_addr", 32'(imem_addr), 32'h0100);

    wait_for(0, "timeout_i0", w);
    t1 = cyc;
    check_eq("i0_instr", 32'(instr), 32'h1234);
    check_eq("i0_pc", 32'(pc_out), 32'h0100);
    check_eq("i0_pc2", 32'(pc_plus2), 32'h0102);
    tick();
    wait_for(0, "timeout_i1", w);
    t2 = cyc;
    check_eq("spacing", 32'(t2 - t1), 32'(SPACING));
    check_eq("i1_instr", 32'(instr), 32'h5678);
    check_eq("i1_pc", 32'(pc_out), 32'h0102);
    check_eq("i1_pc2", 32'(pc_plus2), 32'h0104);
    tick();
    wait_for(0, "timeout_hlt", w);
    check_eq("hlt_instr", 32'(instr), 32'hF000);
    check_eq("hlt_pc", 32'(pc_out), 32'h0104);
    check_eq("hlt_halted", 32'(halted), 32'd1);
    nreq = 0;
    repeat (20) begin
      tick();
      if (imem_req) nreq++;
    end
    check_eq("halt_no_req", 32'(nreq), 32'd0);
    check_eq("halt_held", 32'(halted), 32'd1);

    mem[16'h0000] = 16'h1111; mem[16'h0002] = 16'hF000;
    redirect(16'h0000);
    check_eq("unhalt_halted", 32'(halted), 32'd0);
    check_eq("unhalt_req", 32'(imem_req), 32'd1);
    check_eq("unhalt_addr", 32'(imem_addr), 32'h0000);
    wait_for(2, "timeout_halt2", w);
    repeat (3) tick();

    mem[16'h0300] = 16'h1234; mem[16'h0302] = 16'h5678; mem[16'h0304] = 16'hF000;
    redirect(16'h0300);
    wait_for(0, "timeout_stall", w);
    stall = 1'b1;
    repeat (5) begin
      tick();
      check_eq("stall_instr", 32'(instr), 32'h1234);
      check_eq("stall_pc", 32'(pc_out), 32'h0300);
      check_eq("stall_valid", 32'(instr_valid), 32'd1);
    end
    stall = 1'b0;
    tick();
`ifdef FETCH_SKID_EN
    check_eq("skid_instr", 32'(instr), 32'h5678);
    check_eq("skid_pc", 32'(pc_out), 32'h0302);
    check_eq("skid_valid", 32'(instr_valid), 32'd1);
`endif
    wait_for(2, "timeout_halt3", w);
    repeat (3) tick();

    mem[16'h0400] = 16'hAAAA; mem[16'h0202] = 16'h7777; mem[16'h0204] = 16'hF000;
    mem_lat = 4;
    redirect(16'h0400);
    check_eq("wait_req", 32'(imem_req), 32'd1);
    check_eq("wait_addr", 32'(imem_addr), 32'h0400);
    tick();
    redirect(16'h0203);
    check_eq("drop_valid", 32'(instr_valid), 32'd0);
    wait_for(1, "timeout_drain_req", w);
    check_eq("drain_delay", 32'(w), 32'd3);
    check_eq("drain_addr", 32'(imem_addr), 32'h0202);
    wait_for(2, "timeout_halt4", w);
    repeat (3) tick();

    mem_lat = 1;
    mem[16'hFFFE] = 16'h4444; mem[16'h0000] = 16'hF000;
    redirect(16'hFFFE);
    wait_for(0, "timeout_wrap", w);
    check_eq("wrap_instr", 32'(instr), 32'h4444);
    check_eq("wrap_pc", 32'(pc_out), 32'hFFFE);
    check_eq("wrap_pc2", 32'(pc_plus2), 32'h0000);
    wait_for(1, "timeout_wrap_req", w);
    check_eq("wrap_req_addr", 32'(imem_addr), 32'h0000);
    wait_for(2, "timeout_halt5", w);
    repeat (3) tick();
    check_eq("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
